// File: rtl/i2c_txn_sequencer.sv
// Register read/write transaction sequencer driving an I2C byte engine.
// One command in flight at a time; a watchdog aborts a stalled engine.
module i2c_txn_sequencer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_txdata,
    input  logic       cmd_done,
    input  logic       cmd_ack,
    input  logic [7:0] cmd_rxdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_status,
    output logic [7:0] rsp_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, S1, DW, RA, WD, S2, DR, RD, SP, RSP
    } state_t;

    localparam logic [2:0] OP_START = 3'd0;
    localparam logic [2:0] OP_STOP  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_RNACK = 3'd4;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_NACK = 2'd1;
    localparam logic [1:0] ST_TO   = 2'd2;

    // Last count before the watchdog hits all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST =
        {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state;
    logic                 waiting;
    logic [TIMEOUT_W-1:0] wdog;
    logic                 rw;
    logic [6:0]           dev;
    logic [7:0]           reg_addr;
    logic [7:0]           wdata;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RSP);

    function automatic logic [2:0] op_of(input state_t s);
        unique case (s)
            S1, S2:         op_of = OP_START;
            DW, RA, WD, DR: op_of = OP_WRITE;
            RD:             op_of = OP_RNACK;
            SP:             op_of = OP_STOP;
            default:        op_of = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] tx_of(input state_t s);
        unique case (s)
            DW:      tx_of = {dev, 1'b0};
            RA:      tx_of = reg_addr;
            WD:      tx_of = wdata;
            DR:      tx_of = {dev, 1'b1};
            default: tx_of = 8'h00;
        endcase
    endfunction

    // Entering a command state opens its ISSUE phase.
    task automatic enter(input state_t s);
        state      <= s;
        waiting    <= 1'b0;
        wdog       <= '0;
        cmd_valid  <= (s != RSP) && (s != IDLE);
        cmd_op     <= op_of(s);
        cmd_txdata <= tx_of(s);
    endtask

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waiting    <= 1'b0;
            wdog       <= '0;
            rw         <= 1'b0;
            dev        <= 7'h00;
            reg_addr   <= 8'h00;
            wdata      <= 8'h00;
            cmd_valid  <= 1'b0;
            cmd_op     <= 3'd0;
            cmd_txdata <= 8'h00;
            rsp_status <= ST_OK;
            rsp_rdata  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        rw         <= req_rw;
                        dev        <= req_dev;
                        reg_addr   <= req_reg;
                        wdata      <= req_wdata;
                        rsp_status <= ST_OK;
                        rsp_rdata  <= 8'h00;
                        enter(S1);
                    end
                end
                RSP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: begin
                    if (wdog == WD_LAST) begin
                        rsp_status <= ST_TO;
                        rsp_rdata  <= 8'h00;
                        enter(RSP);
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (!waiting) begin
                            if (cmd_ready) begin
                                cmd_valid <= 1'b0;
                                waiting   <= 1'b1;
                            end
                        end else if (cmd_done) begin
                            unique case (state)
                                S1: enter(DW);
                                S2: enter(DR);
                                SP: enter(RSP);
                                RD: begin
                                    rsp_rdata <= cmd_rxdata;
                                    enter(SP);
                                end
                                RA: begin
                                    if (!cmd_ack) begin
                                        rsp_status <= ST_NACK;
                                        enter(SP);
                                    end else if (rw) begin
                                        enter(S2);
                                    end else begin
                                        enter(WD);
                                    end
                                end
                                WD: begin
                                    if (!cmd_ack) rsp_status <= ST_NACK;
                                    enter(SP);
                                end
                                DW: begin
                                    if (cmd_ack) begin
                                        enter(RA);
                                    end else begin
                                        rsp_status <= ST_NACK;
                                        enter(SP);
                                    end
                                end
                                DR: begin
                                    if (cmd_ack) begin
                                        enter(RD);
                                    end else begin
                                        rsp_status <= ST_NACK;
                                        enter(SP);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural byte engine.
// Logged commands are {op[2:0], txdata[7:0]}.
module tb_i2c_txn_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_txdata;
    logic       cmd_done;
    logic       cmd_ack;
    logic [7:0] cmd_rxdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic [7:0] rsp_rdata;
    logic       busy;

    i2c_txn_sequencer #(.TIMEOUT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_txdata(cmd_txdata),
        .cmd_done(cmd_done), .cmd_ack(cmd_ack),
        .cmd_rxdata(cmd_rxdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [6:0]  dev;
        logic [7:0]  ra;
        logic [7:0]  wd;
        logic [7:0]  rx;
        int          nack;
        logic [1:0]  st;
        logic [7:0]  rd;
        int          n;
        logic [10:0] ops [8];
    } vec_t;

    vec_t        vt [7];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    logic [10:0] op_log [256];
    int          nack_idx = -1;
    bit          hang = 1'b0;
    int          rdy_hold = 0;
    logic [7:0]  rx_val = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Command monitor: logs every accepted command handshake.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset && cmd_valid && cmd_ready) begin
                if (hs_cnt < 256) op_log[hs_cnt] = {cmd_op, cmd_txdata};
                hs_cnt++;
            end
        end
    end

    // Byte engine: ready after rdy_hold cycles, done 3 cycles after accept.
    initial begin
        int seen;
        int cnt;
        int wcnt;
        bit pend;
        bit ackn;
        seen = 0; cnt = 0; wcnt = 0; pend = 0; ackn = 0;
        cmd_ready = 0; cmd_done = 0; cmd_ack = 0; cmd_rxdata = 0;
        forever begin
            @(negedge clk);
            cmd_done = 0;
            if (reset) begin
                cmd_ready = 0;
                pend = 0;
                wcnt = 0;
                seen = hs_cnt;
            end else if (hs_cnt != seen) begin
                seen = hs_cnt;
                cmd_ready = 0;
                pend = 1;
                cnt = 3;
                wcnt = 0;
                ackn = ((hs_cnt - 1) == nack_idx);
            end else if (pend) begin
                if (cnt > 0) cnt--;
                if (cnt == 0 && !hang) begin
                    pend = 0;
                    cmd_done = 1;
                    cmd_ack = !ackn;
                    cmd_rxdata = rx_val;
                end
            end else if (cmd_valid && !cmd_ready) begin
                if (wcnt >= rdy_hold) cmd_ready = 1;
                else wcnt++;
            end
        end
    end

    task automatic do_req(input logic rw, input logic [6:0] d,
                          input logic [7:0] r, input logic [7:0] w,
                          output int acc);
        int k;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("req_ready_wait", 0, 1);
        req_valid = 1; req_rw = rw; req_dev = d;
        req_reg = r; req_wdata = w;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        acc = cyc;
    endtask

    task automatic wait_rsp();
        int k;
        k = 0;
        while (!rsp_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) chk("rsp_wait", 0, 1);
    endtask

    task automatic ack_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
        chk("idle_ready", req_ready, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_op"}, cmd_op, 0);
        chk({tag, "_cmd_txdata"}, cmd_txdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_status"}, rsp_status, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_vec(input int i);
        int base;
        int acc;
        int n;
        base = hs_cnt;
        nack_idx = (vt[i].nack < 0) ? -1 : base + vt[i].nack;
        rx_val = vt[i].rx;
        do_req(vt[i].rw, vt[i].dev, vt[i].ra, vt[i].wd, acc);
        wait_rsp();
        chk($sformatf("v%0d_status", i), rsp_status, vt[i].st);
        chk($sformatf("v%0d_rdata", i), rsp_rdata, vt[i].rd);
        n = hs_cnt - base;
        chk($sformatf("v%0d_nops", i), n, vt[i].n);
        for (int k = 0; k < vt[i].n && k < n; k++)
            chk($sformatf("v%0d_op%0d", i, k),
                op_log[base + k], vt[i].ops[k]);
        ack_rsp();
        nack_idx = -1;
    endtask

    initial begin
        int base;
        int acc;
        int k;
        reset = 1; req_valid = 0; req_rw = 0; req_dev = 0;
        req_reg = 0; req_wdata = 0; rsp_ready = 0;

        vt[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h77, -1, 2'd0, 8'h00, 5,
                  '{11'h000, 11'h2A0, 11'h210, 11'h2A5, 11'h100,
                    11'h0, 11'h0, 11'h0}};
        vt[1] = '{1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, -1, 2'd0, 8'h3C, 7,
                  '{11'h000, 11'h2A0, 11'h220, 11'h000, 11'h2A1,
                    11'h400, 11'h100, 11'h0}};
        vt[2] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h77, 1, 2'd1, 8'h00, 3,
                  '{11'h000, 11'h2A0, 11'h100, 11'h0, 11'h0,
                    11'h0, 11'h0, 11'h0}};
        vt[3] = '{1'b0, 7'h23, 8'h44, 8'h99, 8'h11, 3, 2'd1, 8'h00, 5,
                  '{11'h000, 11'h246, 11'h244, 11'h299, 11'h100,
                    11'h0, 11'h0, 11'h0}};
        vt[4] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 8'hFF, -1, 2'd0, 8'hFF, 7,
                  '{11'h000, 11'h2FE, 11'h2FF, 11'h000, 11'h2FF,
                    11'h400, 11'h100, 11'h0}};
        vt[5] = '{1'b1, 7'h12, 8'h34, 8'h00, 8'h55, 4, 2'd1, 8'h00, 6,
                  '{11'h000, 11'h224, 11'h234, 11'h000, 11'h225,
                    11'h100, 11'h0, 11'h0}};
        vt[6] = '{1'b1, 7'h01, 8'h00, 8'h00, 8'h66, 2, 2'd1, 8'h00, 4,
                  '{11'h000, 11'h202, 11'h200, 11'h100, 11'h0,
                    11'h0, 11'h0, 11'h0}};

        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Engine stalls after START: watchdog aborts, no STOP.
        hang = 1;
        base = hs_cnt;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, acc);
        wait_rsp();
        chk("to_cycles", cyc - acc, 15);
        chk("to_status", rsp_status, 2);
        chk("to_rdata", rsp_rdata, 0);
        chk("to_nops", hs_cnt - base, 1);
        chk("to_op0", op_log[base], 11'h000);
        hang = 0;
        repeat (5) @(negedge clk);
        chk("to_hold", rsp_valid, 1);
        chk("to_hold_status", rsp_status, 2);
        ack_rsp();
        run_vec(1);

        // Slow cmd_ready, then a slow response consumer.
        rdy_hold = 4;
        base = hs_cnt;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, acc);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("iss_valid%0d", j), cmd_valid, 1);
            chk($sformatf("iss_cmd%0d", j), {cmd_op, cmd_txdata}, 0);
            @(negedge clk);
        end
        wait_rsp();
        chk("slow_nops", hs_cnt - base, 5);
        chk("slow_op3", op_log[base + 3], 11'h2A5);
        req_valid = 1; req_rw = 1; req_dev = 7'h11;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("hold_valid%0d", j), rsp_valid, 1);
            chk($sformatf("hold_status%0d", j), rsp_status, 0);
            chk($sformatf("hold_rdata%0d", j), rsp_rdata, 0);
            chk($sformatf("hold_noacc%0d", j), req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        req_valid = 0;
        chk("hs_rsp_drop", rsp_valid, 0);
        chk("hs_idle_busy", busy, 0);
        @(negedge clk);
        chk("hs_not_taken", busy, 0);
        rdy_hold = 0;

        // Reset in the WAIT of the register-address byte.
        base = hs_cnt;
        do_req(1'b0, 7'h50, 8'h10, 8'hA5, acc);
        k = 0;
        while (hs_cnt < base + 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ra_reached", hs_cnt - base, 3);
        reset = 1;
        @(negedge clk);
        chk_reset("mid");
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("mid_no_stop", hs_cnt - base, 3);
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
